// File: rtl/out_port_fifo_if.sv
// Handshake and data bundle between the NibblER decode/bus side, the output FIFO
// and its downstream consumer.
interface out_port_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          loadOut;
    logic [3:0]    D;
    logic          out_ready;
    logic          clr_ovf;
    logic          out_valid;
    logic [3:0]    out_nibble;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output loadOut, D, out_ready, clr_ovf,
        input  out_valid, out_nibble, full, empty, count, overflow
    );

    modport slave (
        input  loadOut, D, out_ready, clr_ovf,
        output out_valid, out_nibble, full, empty, count, overflow
    );
endinterface

// File: rtl/out_port_fifo.sv
// Buffered CPU output port: captures bus nibbles on loadOut into a first-word
// fall-through FIFO, drains them over valid/ready, and flags dropped pushes.
module out_port_fifo #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    out_port_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic full_w;
    logic empty_w;
    logic pop;
    logic push;
    logic drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop  = !empty_w && bus.out_ready;
    assign push = bus.loadOut && (!full_w || pop);
    assign drop = bus.loadOut && full_w && !pop;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = !empty_w;
    assign bus.out_nibble = empty_w ? 4'b0000 : mem[rd_ptr];
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Buffered output port for the NibblER 4-bit CPU, sitting directly downstream of the microROM decode and the shared 4-bit data bus. When the decoder asserts `loadOut`, the nibble on the bus is captured into a small FIFO. It is then presented to an external consumer over a valid/ready handshake, so a slow peripheral never loses CPU output. Overflow is reported through a sticky flag, because the CPU core has no stall path.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `loadOut` in 1: push request from microROM decode; sampled every rising edge.
- `D` in 4: shared data bus (busDriver output), captured on an accepted push.
- `out_ready` in 1: consumer can accept the head nibble this cycle.
- `clr_ovf` in 1: clears the sticky overflow flag.
- `out_valid` out 1: head entry present (`!empty`).
- `out_nibble` out 4: head entry; `4'b0000` when empty.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out log2(DEPTH)+1: number of occupied entries, 0..DEPTH.
- `overflow` out 1: sticky flag; a push was dropped.

## Operation
- Storage: DEPTH×4 array plus write pointer `wr_ptr` and read pointer `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH. The array is not reset.
- Pop: `pop = out_valid && out_ready`. On pop, `rd_ptr` increments.
- Push: `push = loadOut && (!full || pop)`. On push, `mem[wr_ptr] <= D` and `wr_ptr` increments.
- Dropped push: `loadOut && full && !pop`. `D` is discarded, pointers and count are unchanged, and `overflow` is set.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Read is first-word fall-through: `out_nibble = mem[rd_ptr]` combinationally when `!empty`, else 0.
- `full`, `empty` and `out_valid` are derived from the registered `count`.
- `overflow` clears on `clr_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- No dependence on `phase`. The decoder only asserts `loadOut` in the execute phase, and the block takes every asserted `loadOut` at face value.
- If `loadOut` is held high for k cycles, k pushes are attempted.

## Timing
- Reset (synchronous, at the edge with `reset`=1): `wr_ptr`=`rd_ptr`=0, `count`=0, `overflow`=0.
  - Outputs then read: `out_valid`=0, `empty`=1, `full`=0, `out_nibble`=0.
  - Reset overrides push, pop and `clr_ovf` in the same cycle.
  - Reset in the middle of a burst discards all contents.
- Push-to-valid latency is 1 edge. A push at edge N makes `out_valid`=1 and `out_nibble`=D after edge N.
  - There is no bypass: when empty, a push and `out_ready` in the same cycle still cause no pop that cycle.
- Pop takes effect at the edge. After the edge, the next entry (or 0 if now empty) appears combinationally.
- Full with push+pop in the same cycle: both occur, `count` stays at DEPTH, and `overflow` is not set.
- Empty with `out_ready`=1 and no push: nothing happens and `count` stays 0.
- `out_nibble` must hold stable while `out_valid`=1 and `out_ready`=0.
- Wrap-around: after DEPTH pushes and DEPTH pops, the pointers return to 0 and FIFO order is preserved across the wrap.

## Test plan
- Reset then idle: assert `reset` 1 cycle with `loadOut`=1 and `D`=4'hA → after the edge `count`=0, `empty`=1, `out_valid`=0, `out_nibble`=0, `overflow`=0.
- Order and latency: push 4'h3, 4'h7, 4'hC on consecutive edges with `out_ready`=0 → `out_valid` rises after the first edge; `count`=3 and `out_nibble`=3. Then `out_ready`=1 for 3 cycles → outputs 3, 7, C in order, then `empty`=1.
- Overflow: DEPTH=4, push 1,2,3,4 → `full`=1. Push 5 with `out_ready`=0 → `overflow`=1 and `count`=4. Drain → 1,2,3,4 and 5 absent. Pulse `clr_ovf` → `overflow`=0.
- Full + simultaneous push/pop: when full with head=1, `loadOut`=1, `D`=9, `out_ready`=1 → `count` stays 4, head becomes 2, `overflow`=0. Drain yields 2,3,4,9.
- Wrap-around: 10 interleaved push/pop cycles with DEPTH=4, data 0..9 → output sequence 0..9, `count` never exceeds 4. Same-cycle `clr_ovf` with a drop → `overflow` stays 1.
- Reset mid-operation: with 3 entries queued, assert `reset` together with `out_ready`=1 → after the edge `count`=0 and `out_valid`=0. A subsequent push of 4'hE appears as the head after 1 edge.
